pc_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32 core. It sequences fetch/decode/execute/writeback around the program counter.
- Fetch: runs the instruction-memory request/ready handshake and latches the instruction register (IR).
- Writeback: pulses the PC enable and drives the PC next-address select from the resolved control-flow type.
- Also owns the halt/resume, fetch-timeout fault and retired-instruction counter.

---
 rtl/pc_sequencer_pkg.sv | 30 +++
 rtl/pc_sequencer_fetch_timer.sv | 27 ++
 rtl/pc_sequencer.sv | 107 ++++++++++
 tb/tb_pc_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the RV32 multi-cycle sequencer and the program counter mux.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        TRAP   = 3'd6
    } state_e;

    // PC next-address select; 2'b11 is reserved and the PC treats it as PC4.
    localparam logic [1:0] PC4      = 2'b00;
    localparam logic [1:0] ALU_OUT  = 2'b01;
    localparam logic [1:0] PC_ADDER = 2'b10;

    // JALR target comes from the ALU and overrides any other control-flow flag.
    function automatic logic [1:0] pc_sel(input logic jal, input logic jalr,
                                          input logic branch, input logic taken);
        if (jalr)
            return ALU_OUT;
        else if (jal || (branch && taken))
            return PC_ADDER;
        else
            return PC4;
    endfunction

endpackage

// File: rtl/pc_sequencer_fetch_timer.sv
// Fetch timeout down-counter: reloads on clr, counts while en, flags the last allowed cycle.
module pc_sequencer_fetch_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LOAD = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= LOAD;
        else if (clr)
            cnt <= LOAD;
        else if (en && cnt != 8'd0)
            cnt <= cnt - 8'd1;
    end

    assign expired = en && (cnt == 8'd0);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback control FSM with halt, fetch timeout and instret.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 16,
    parameter int INSTRET_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    input  logic                 imem_ready,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          instr,
    input  logic                 exec_done,
    input  logic                 is_jal,
    input  logic                 is_jalr,
    input  logic                 is_branch,
    input  logic                 branch_taken,
    output logic                 pc_en,
    output logic [1:0]           pc_branch,
    output logic                 retire,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic                 halted,
    output logic                 fault,
    output logic [INSTRET_W-1:0] instret,
    output logic [2:0]           state
);

    state_e     cur, nxt;
    logic [1:0] br_q;
    logic       to_en, to_clr, to_exp;

    assign to_en  = (cur == FETCH);
    assign to_clr = !to_en || imem_ready;

    pc_sequencer_fetch_timer #(.TIMEOUT(FETCH_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cur <= IDLE;
        else
            cur <= nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr   <= '0;
            instret <= '0;
            br_q    <= PC4;
        end else begin
            if (cur == FETCH && imem_ready)
                instr <= imem_rdata;
            // Select is captured at execute exit so WB drives a clean registered value.
            if (cur == EXEC && exec_done)
                br_q <= pc_sel(is_jal, is_jalr, is_branch, branch_taken);
            else if (cur == WB)
                br_q <= PC4;
            if (cur == WB)
                instret <= instret + INSTRET_W'(1);
        end
    end

    always_comb begin
        nxt       = cur;
        imem_req  = 1'b0;
        pc_en     = 1'b0;
        pc_branch = PC4;
        retire    = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        case (cur)
            IDLE:   nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready)
                    nxt = DECODE;
                else if (to_exp)
                    nxt = TRAP;
            end
            DECODE: nxt = EXEC;
            EXEC:   if (exec_done) nxt = WB;
            WB: begin
                pc_en     = 1'b1;
                retire    = 1'b1;
                pc_branch = br_q;
                nxt       = halt_req ? HALT : FETCH;
            end
            HALT: begin
                halted = 1'b1;
                if (resume)
                    nxt = FETCH;
            end
            TRAP:   fault = 1'b1;
            default: nxt = IDLE;
        endcase
    end

    assign state = cur;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized instruction-level bench for pc_sequencer with a transaction reference model.
module tb_pc_sequencer;

    localparam int TO  = 6;
    localparam int IW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req;
    logic          imem_ready;
    logic [31:0]   imem_rdata;
    logic [31:0]   instr;
    logic          exec_done;
    logic          is_jal, is_jalr, is_branch, branch_taken;
    logic          pc_en;
    logic [1:0]    pc_branch;
    logic          retire;
    logic          halt_req, resume;
    logic          halted, fault;
    logic [IW-1:0] instret;
    logic [2:0]    state;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_instret = 0;
    int n_retire = 0;

    pc_sequencer #(.FETCH_TIMEOUT(TO), .INSTRET_W(IW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .exec_done    (exec_done),
        .is_jal       (is_jal),
        .is_jalr      (is_jalr),
        .is_branch    (is_branch),
        .branch_taken (branch_taken),
        .pc_en        (pc_en),
        .pc_branch    (pc_branch),
        .retire       (retire),
        .halt_req     (halt_req),
        .resume       (resume),
        .halted       (halted),
        .fault        (fault),
        .instret      (instret),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected PC select from the control-flow rules: JALR wins, then JAL / taken branch.
    function automatic int exp_sel(input bit jal, input bit jalr, input bit br, input bit tk);
        if (jalr) return 1;
        if (jal || (br && tk)) return 2;
        return 0;
    endfunction

    // Runs one instruction starting from a negedge with the DUT in FETCH.
    task automatic run_instr(input logic [31:0] rd, input int rdy_dly, input int ex_dly,
                             input bit jal, input bit jalr, input bit br, input bit tk,
                             input bit halt_dec, input bit halt_wb);
        for (int i = 0; i < rdy_dly; i++) begin
            chk("fetch_req", 32'(imem_req), 32'd1);
            chk("fetch_pc_en", 32'(pc_en), 32'd0);
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            halt_req   = 1'($urandom_range(0, 1));
            step();
        end
        chk("fetch_state", 32'(state), 32'd1);
        imem_ready = 1'b1;
        imem_rdata = rd;
        step();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        chk("decode_state", 32'(state), 32'd2);
        chk("instr", instr, rd);
        chk("decode_pc_en", 32'(pc_en), 32'd0);
        halt_req     = halt_dec;
        is_jal       = jal;
        is_jalr      = jalr;
        is_branch    = br;
        branch_taken = tk;
        step();
        for (int i = 0; i <= ex_dly; i++) begin
            chk("exec_state", 32'(state), 32'd3);
            chk("exec_pc_en", 32'(pc_en), 32'd0);
            chk("exec_retire", 32'(retire), 32'd0);
            halt_req  = 1'($urandom_range(0, 1));
            exec_done = (i == ex_dly);
            step();
        end
        exec_done = 1'b0;
        chk("wb_state", 32'(state), 32'd4);
        chk("wb_pc_en", 32'(pc_en), 32'd1);
        chk("wb_retire", 32'(retire), 32'd1);
        chk("wb_pc_branch", 32'(pc_branch), 32'(exp_sel(jal, jalr, br, tk)));
        chk("wb_instr_hold", instr, rd);
        halt_req = halt_wb;
        step();
        n_retire++;
        exp_instret = (exp_instret + 1) % (1 << IW);
        halt_req = 1'b0;
        chk("instret", 32'(instret), 32'(exp_instret));
        chk("post_wb_pc_en", 32'(pc_en), 32'd0);
        chk("post_wb_pc_branch", 32'(pc_branch), 32'd0);
        if (halt_wb) begin
            int n = $urandom_range(0, 3);
            for (int i = 0; i <= n; i++) begin
                chk("halted", 32'(halted), 32'd1);
                chk("halt_req_off", 32'(imem_req), 32'd0);
                halt_req = 1'($urandom_range(0, 1));
                step();
            end
            halt_req = 1'b0;
            resume   = 1'b1;
            step();
            resume = 1'b0;
            chk("resume_halted", 32'(halted), 32'd0);
        end
        chk("next_fetch_state", 32'(state), 32'd1);
        chk("next_fetch_req", 32'(imem_req), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        imem_ready = 1'b0; imem_rdata = '0; exec_done = 1'b0;
        is_jal = 1'b0; is_jalr = 1'b0; is_branch = 1'b0; branch_taken = 1'b0;
        halt_req = 1'b0; resume = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        chk("rst_outputs", {26'd0, imem_req, pc_en, pc_branch, retire, halted | fault}, 32'd0);
        rst_n = 1'b1;
        chk("idle_req", 32'(imem_req), 32'd0);
        step();
        chk("first_fetch", 32'(imem_req), 32'd1);

        // Directed: simple ADDI, then JALR / JAL / not-taken branch, then delayed taken branch.
        run_instr(32'h0050_0093, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("instret_first", 32'(instret), 32'd1);
        run_instr(32'h0000_8067, 1, 0, 0, 1, 0, 0, 0, 0);
        run_instr(32'h0080_006f, 0, 0, 1, 0, 0, 0, 0, 0);
        run_instr(32'h0020_8463, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("retire_count", 32'(n_retire), 32'(instret));
        run_instr(32'h0020_8463, 0, 5, 0, 0, 1, 1, 1, 0);
        // Ready on the last allowed fetch cycle beats the timeout; then halt at WB.
        run_instr(32'h1234_5678, TO - 1, 1, 1, 1, 1, 1, 0, 1);

        for (int n = 0; n < 24; n++)
            run_instr($urandom, $urandom_range(0, TO - 1), $urandom_range(0, 4),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));

        // Reset while in EXEC aborts the instruction.
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
        chk("abort_exec_state", 32'(state), 32'd3);
        exec_done = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        exp_instret = 0;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_pc_en", 32'(pc_en), 32'd0);
        chk("abort_retire", 32'(retire), 32'd0);
        chk("abort_instret", 32'(instret), 32'(exp_instret));
        exec_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("abort_refetch", 32'(state), 32'd1);

        // Fetch timeout.
        for (int i = 0; i < TO; i++) begin
            chk("to_wait_fault", 32'(fault), 32'd0);
            chk("to_wait_req", 32'(imem_req), 32'd1);
            step();
        end
        chk("trap_fault", 32'(fault), 32'd1);
        chk("trap_state", 32'(state), 32'd6);
        chk("trap_req", 32'(imem_req), 32'd0);
        imem_ready = 1'b1;
        resume     = 1'b1;
        repeat (3) step();
        chk("trap_sticky", 32'(state), 32'd6);
        chk("trap_pc_en", 32'(pc_en), 32'd0);
        imem_ready = 1'b0;
        resume     = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("trap_rst_state", 32'(state), 32'd0);
        chk("trap_rst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("trap_rst_fetch", 32'(state), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
